prio_request_scheduler: RTL and testbench

- Holds up to DEPTH pending memory requests, each a 12-bit word {key[7:0], id[3:0]}.
- Always presents the highest-key request at the head for issue.
- Keeps its buffer sorted with odd-even transposition, one phase per cycle, using sort_two compare-exchange cells.
- Sits between the request front-end (push side) and the command issue stage (pop side).

---
 rtl/mp_sched_pkg.sv | 19 +
 rtl/sort_two.sv | 21 ++
 rtl/prio_request_scheduler.sv | 113 +++++++++++
 tb/tb_prio_request_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mp_sched_pkg.sv
// Shared types and widths for the priority request scheduler.
// A request word is {key, id}; only the key takes part in ordering.
package mp_sched_pkg;

    localparam int unsigned KEY_W = 8;
    localparam int unsigned ID_W  = 4;
    localparam int unsigned REQ_W = KEY_W + ID_W;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [ID_W-1:0]  id;
    } req_t;

    typedef enum logic {
        S_READY = 1'b0,
        S_SORT  = 1'b1
    } state_t;

endpackage

// File: rtl/sort_two.sv
// Compare-exchange cell: in0 is the younger (lower) slot, in1 the older (upper) slot.
// Swaps only on a strictly greater key so equal keys keep arrival order.
module sort_two #(
    parameter int unsigned KEY_W = 8,
    parameter int unsigned ID_W  = 4
) (
    input  logic [KEY_W+ID_W-1:0] in0,
    input  logic [KEY_W+ID_W-1:0] in1,
    output logic [KEY_W+ID_W-1:0] max_out,
    output logic [KEY_W+ID_W-1:0] min_out
);

    localparam int unsigned W = KEY_W + ID_W;

    logic swap;

    assign swap    = in0[W-1:ID_W] > in1[W-1:ID_W];
    assign max_out = swap ? in0 : in1;
    assign min_out = swap ? in1 : in0;

endmodule

// File: rtl/prio_request_scheduler.sv
// Sorted request buffer: head (slot 0) always holds the highest key once sorted.
// Each push triggers DEPTH odd-even transposition phases before the head is offered again.
module prio_request_scheduler #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned KEY_W = mp_sched_pkg::KEY_W,
    parameter int unsigned ID_W  = mp_sched_pkg::ID_W,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [KEY_W+ID_W-1:0]   in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [KEY_W+ID_W-1:0]   out_data,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        count,
    output logic                    busy
);

    import mp_sched_pkg::*;

    localparam int unsigned W    = KEY_W + ID_W;
    localparam int unsigned PH_W = $clog2(DEPTH);
    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(DEPTH - 1);

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [PH_W-1:0]  phase_q;
    logic [W-1:0]     slot_q   [DEPTH];
    logic [W-1:0]     cell_max [DEPTH-1];
    logic [W-1:0]     cell_min [DEPTH-1];

    logic             push;
    logic             pop;
    logic [PH_W-1:0]  wr_idx;

    assign in_ready  = (state_q == S_READY) && (count_q < CNT_W'(DEPTH));
    assign out_valid = (state_q == S_READY) && (count_q != '0);
    assign out_data  = slot_q[0];
    assign count     = count_q;
    assign busy      = (state_q == S_SORT);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // On a simultaneous pop the buffer shifts up first, so the new entry lands one slot lower.
    always_comb begin
        wr_idx = PH_W'(count_q);
        if (pop) begin
            wr_idx = PH_W'(count_q - CNT_W'(1));
        end
    end

    for (genvar g = 0; g < DEPTH - 1; g++) begin : g_cell
        sort_two #(
            .KEY_W (KEY_W),
            .ID_W  (ID_W)
        ) u_sort_two (
            .in0     (slot_q[g+1]),
            .in1     (slot_q[g]),
            .max_out (cell_max[g]),
            .min_out (cell_min[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_READY;
            count_q <= '0;
            phase_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                S_READY: begin
                    if (pop) begin
                        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                            slot_q[i] <= slot_q[i+1];
                        end
                    end
                    if (push) begin
                        slot_q[wr_idx] <= in_data;
                        state_q        <= S_SORT;
                        phase_q        <= '0;
                    end
                    if (push && !pop) begin
                        count_q <= count_q + CNT_W'(1);
                    end else if (pop && !push) begin
                        count_q <= count_q - CNT_W'(1);
                    end
                end
                S_SORT: begin
                    // Even phases pair (2k,2k+1), odd phases (2k+1,2k+2); pairs past count hold.
                    for (int u = 0; u < int'(DEPTH) - 1; u++) begin
                        if ((u[0] == phase_q[0]) && (CNT_W'(u + 1) < count_q)) begin
                            slot_q[u]   <= cell_max[u];
                            slot_q[u+1] <= cell_min[u];
                        end
                    end
                    phase_q <= phase_q + PH_W'(1);
                    if (phase_q == LAST_PHASE) begin
                        state_q <= S_READY;
                        phase_q <= '0;
                    end
                end
                default: state_q <= S_READY;
            endcase
        end
    end

endmodule

// File: tb/tb_prio_request_scheduler.sv
// Directed and random checks of the scheduler against a sorted-queue reference model.
module tb_prio_request_scheduler;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [11:0] out_data;
    logic        out_ready;
    logic [3:0]  count;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    logic [11:0] q[$];
    int          sort_left = 0;

    prio_request_scheduler u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Highest key first; a new entry goes behind all entries with an equal or larger key.
    task automatic model_insert(input logic [11:0] d);
        int pos;
        pos = q.size();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i][11:4] < d[11:4]) begin
                pos = i;
                break;
            end
        end
        q.insert(pos, d);
    endtask

    task automatic step();
        bit eb;
        bit eir;
        bit eov;
        eb  = sort_left > 0;
        eir = !eb && (q.size() < DEPTH);
        eov = !eb && (q.size() != 0);
        chk("busy", 32'(busy), 32'(eb));
        chk("in_ready", 32'(in_ready), 32'(eir));
        chk("out_valid", 32'(out_valid), 32'(eov));
        chk("count", 32'(count), q.size());
        if (eov) chk("out_data", 32'(out_data), 32'(q[0]));
        if (eb) begin
            sort_left--;
        end else begin
            if (out_ready && eov) void'(q.pop_front());
            if (in_valid && eir) begin
                model_insert(in_data);
                sort_left = DEPTH;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && sort_left > 0; i++) step();
    endtask

    task automatic push(input logic [11:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        wait_idle();
    endtask

    task automatic pop_expect(input logic [11:0] d);
        chk("pop_head", 32'(out_data), 32'(d));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step();

        // Basic ordering
        push(12'h101);
        push(12'h402);
        push(12'h203);
        pop_expect(12'h402);
        pop_expect(12'h203);
        pop_expect(12'h101);
        chk("empty_count", 32'(count), 0);

        // Equal keys keep arrival order
        push(12'h551);
        push(12'h552);
        pop_expect(12'h551);
        pop_expect(12'h552);

        // Fill to capacity; an extra request is held off
        for (int k = 1; k <= 8; k++) push(12'(k << 4));
        chk("full_count", 32'(count), 8);
        chk("full_in_ready", 32'(in_ready), 0);
        in_valid = 1'b1;
        in_data  = 12'h090;
        step();
        step();
        in_valid = 1'b0;
        chk("full_hold_count", 32'(count), 8);
        pop_expect(12'h080);
        while (q.size() != 0) pop_expect(q[0]);

        // Simultaneous push and pop
        push(12'h300);
        push(12'h200);
        in_valid  = 1'b1;
        in_data   = 12'h250;
        out_ready = 1'b1;
        chk("pp_head", 32'(out_data), 32'h300);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("pp_count", 32'(count), 2);
        chk("pp_busy", 32'(busy), 1);
        wait_idle();
        pop_expect(12'h250);
        pop_expect(12'h200);

        // Inputs ignored while sorting
        in_valid  = 1'b1;
        in_data   = 12'h123;
        step();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("ign_count", 32'(count), 1);
        pop_expect(12'h123);

        // Asynchronous reset during phase 3
        in_valid = 1'b1;
        in_data  = 12'h7F0;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_count", 32'(count), 0);
        chk("mrst_out_valid", 32'(out_valid), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_in_ready", 32'(in_ready), 1);
        q.delete();
        sort_left = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic with frequent key ties
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = {8'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) step();
        out_ready = 1'b0;
        chk("drain_count", 32'(count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
